// File: rtl/mips_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_bus_pkg : shared types and constants for the MIPS Avalon-MM bus.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mips_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam int ARB_RR     = 0;
   localparam int ARB_FIXED  = 1;
   localparam int BUS_DATA_W = 32;
   localparam int BUS_BE_W   = 4;

   // Index width that stays legal when only one requester exists.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mips_rr_select.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_rr_select : combinational N-way rotating / fixed priority encoder.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mips_rr_select
   import mips_bus_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int IDX_W = 1
)(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             fixed_mode,
   output logic [IDX_W-1:0] winner,
   output logic             any_req
);

   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   int                 base;
   int                 pos;

   // Rotate the request vector so the search always starts at bit 0.
   always_comb begin
      dbl     = {req, req};
      base    = 0;
      pos     = 0;
      any_req = |req;
      if (!fixed_mode) begin
         base = (int'(ptr) + 1) % N_REQ;
      end
      rot = N_REQ'(dbl >> base);
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            pos = i;
         end
      end
      winner = IDX_W'((base + pos) % N_REQ);
   end

endmodule
`default_nettype wire

// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_bus_arbiter : N-requester Avalon-MM arbiter with waitrequest abort. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mips_bus_arbiter
   import mips_bus_pkg::*;
#(
   parameter int                    N_REQ    = 2,
   parameter int                    ADDR_W   = 32,
   parameter int                    ARB_MODE = ARB_RR,
   parameter int                    TIMEOUT  = 255,
   parameter logic [BUS_DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic [N_REQ*ADDR_W-1:0]        up_address,
   input  logic [N_REQ-1:0]               up_read,
   input  logic [N_REQ-1:0]               up_write,
   input  logic [N_REQ*BUS_DATA_W-1:0]    up_writedata,
   input  logic [N_REQ*BUS_BE_W-1:0]      up_byteenable,
   output logic [N_REQ-1:0]               up_waitrequest,
   output logic [BUS_DATA_W-1:0]          up_readdata,
   output logic [ADDR_W-1:0]              address,
   output logic                           read,
   output logic                           write,
   output logic [BUS_DATA_W-1:0]          writedata,
   output logic [BUS_BE_W-1:0]            byteenable,
   input  logic                           waitrequest,
   input  logic [BUS_DATA_W-1:0]          readdata,
   output logic [idx_w(N_REQ)-1:0]        grant,
   output logic                           busy,
   output logic                           bus_err
);

   localparam int               IDX_W      = idx_w(N_REQ);
   localparam int               CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT);
   localparam logic             FIXED_MODE = (ARB_MODE == ARB_FIXED);

   arb_state_t             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [IDX_W-1:0]       grant_q, grant_d;
   logic [ADDR_W-1:0]      address_q, address_d;
   logic                   read_q, read_d;
   logic                   write_q, write_d;
   logic [BUS_DATA_W-1:0]  writedata_q, writedata_d;
   logic [BUS_BE_W-1:0]    byteenable_q, byteenable_d;
   logic [N_REQ-1:0]       up_waitrequest_q, up_waitrequest_d;
   logic [BUS_DATA_W-1:0]  up_readdata_q, up_readdata_d;
   logic                   busy_q, busy_d;
   logic                   bus_err_q, bus_err_d;

   logic [N_REQ-1:0]       req_active;
   logic [IDX_W-1:0]       winner;
   logic                   any_req;
   logic [N_REQ-1:0]       win_onehot;
   logic [N_REQ-1:0]       done_mask;
   logic [ADDR_W-1:0]      sel_addr;
   logic [BUS_DATA_W-1:0]  sel_wdata;
   logic [BUS_BE_W-1:0]    sel_be;
   logic                   sel_read;
   logic                   sel_write;

   assign req_active = up_read | up_write;

   mips_rr_select #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_select (
      .req        (req_active),
      .ptr        (ptr_q),
      .fixed_mode (FIXED_MODE),
      .winner     (winner),
      .any_req    (any_req)
   );

   assign win_onehot = N_REQ'(1) << winner;
   assign done_mask  = ~(N_REQ'(1) << grant_q);
   assign sel_addr   = ADDR_W'(up_address >> (int'(winner) * ADDR_W));
   assign sel_wdata  = BUS_DATA_W'(up_writedata >> (int'(winner) * BUS_DATA_W));
   assign sel_be     = BUS_BE_W'(up_byteenable >> (int'(winner) * BUS_BE_W));
   assign sel_read   = |(up_read & win_onehot);
   // A simultaneous read and write is illegal; the read is honoured.
   assign sel_write  = |(up_write & win_onehot) & ~sel_read;

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      cnt_inc          = cnt_q + 1'b1;
      ptr_d            = ptr_q;
      grant_d          = grant_q;
      address_d        = address_q;
      read_d           = read_q;
      write_d          = write_q;
      writedata_d      = writedata_q;
      byteenable_d     = byteenable_q;
      up_waitrequest_d = '1;
      up_readdata_d    = up_readdata_q;
      busy_d           = busy_q;
      bus_err_d        = 1'b0;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               address_d    = sel_addr;
               read_d       = sel_read;
               write_d      = sel_write;
               writedata_d  = sel_wdata;
               byteenable_d = sel_be;
               grant_d      = winner;
               ptr_d        = winner;
               busy_d       = 1'b1;
               state_d      = BUS;
            end
         end
         BUS: begin
            if (!waitrequest) begin
               if (read_q) begin
                  up_readdata_d = readdata;
               end
               read_d           = 1'b0;
               write_d          = 1'b0;
               up_waitrequest_d = done_mask;
               state_d          = RESP;
            end else begin
               cnt_d = cnt_inc;
               // Abort a hung slave so the requester is never stalled forever.
               if ((TIMEOUT != 0) && (cnt_inc == CNT_LIMIT)) begin
                  read_d           = 1'b0;
                  write_d          = 1'b0;
                  up_readdata_d    = ERR_DATA;
                  bus_err_d        = 1'b1;
                  up_waitrequest_d = done_mask;
                  state_d          = RESP;
               end
            end
         end
         RESP: begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= IDLE;
         cnt_q            <= '0;
         ptr_q            <= IDX_W'(N_REQ - 1);
         grant_q          <= '0;
         address_q        <= '0;
         read_q           <= 1'b0;
         write_q          <= 1'b0;
         writedata_q      <= '0;
         byteenable_q     <= '0;
         up_waitrequest_q <= '1;
         up_readdata_q    <= '0;
         busy_q           <= 1'b0;
         bus_err_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         ptr_q            <= ptr_d;
         grant_q          <= grant_d;
         address_q        <= address_d;
         read_q           <= read_d;
         write_q          <= write_d;
         writedata_q      <= writedata_d;
         byteenable_q     <= byteenable_d;
         up_waitrequest_q <= up_waitrequest_d;
         up_readdata_q    <= up_readdata_d;
         busy_q           <= busy_d;
         bus_err_q        <= bus_err_d;
      end
   end

   assign up_waitrequest = up_waitrequest_q;
   assign up_readdata    = up_readdata_q;
   assign address        = address_q;
   assign read           = read_q;
   assign write          = write_q;
   assign writedata      = writedata_q;
   assign byteenable     = byteenable_q;
   assign grant          = grant_q;
   assign busy           = busy_q;
   assign bus_err        = bus_err_q;

   a_rw_exclusive: assert property (@(posedge clk) disable iff (!reset)
      !(|(up_read & up_write)));

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mips_bus_arbiter : directed bench, round-robin and fixed-priority.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mips_bus_arbiter;

   logic        clk;
   logic        reset;
   logic [63:0] up_address;
   logic [1:0]  up_read;
   logic [1:0]  up_write;
   logic [63:0] up_writedata;
   logic [7:0]  up_byteenable;
   logic        waitrequest;
   logic [31:0] readdata;

   logic [1:0]  rr_uwr, fx_uwr;
   logic [31:0] rr_rdata, fx_rdata;
   logic [31:0] rr_addr, fx_addr;
   logic        rr_read, fx_read;
   logic        rr_write, fx_write;
   logic [31:0] rr_wdata, fx_wdata;
   logic [3:0]  rr_be, fx_be;
   logic        rr_grant, fx_grant;
   logic        rr_busy, fx_busy;
   logic        rr_err, fx_err;

   int n_chk  = 0;
   int n_pass = 0;

   mips_bus_arbiter #(
      .N_REQ (2), .ADDR_W (32), .ARB_MODE (0), .TIMEOUT (8), .ERR_DATA (32'hDEADBEEF)
   ) dut_rr (
      .clk (clk), .reset (reset),
      .up_address (up_address), .up_read (up_read), .up_write (up_write),
      .up_writedata (up_writedata), .up_byteenable (up_byteenable),
      .up_waitrequest (rr_uwr), .up_readdata (rr_rdata),
      .address (rr_addr), .read (rr_read), .write (rr_write),
      .writedata (rr_wdata), .byteenable (rr_be),
      .waitrequest (waitrequest), .readdata (readdata),
      .grant (rr_grant), .busy (rr_busy), .bus_err (rr_err)
   );

   mips_bus_arbiter #(
      .N_REQ (2), .ADDR_W (32), .ARB_MODE (1), .TIMEOUT (8), .ERR_DATA (32'hDEADBEEF)
   ) dut_fx (
      .clk (clk), .reset (reset),
      .up_address (up_address), .up_read (up_read), .up_write (up_write),
      .up_writedata (up_writedata), .up_byteenable (up_byteenable),
      .up_waitrequest (fx_uwr), .up_readdata (fx_rdata),
      .address (fx_addr), .read (fx_read), .write (fx_write),
      .writedata (fx_wdata), .byteenable (fx_be),
      .waitrequest (waitrequest), .readdata (readdata),
      .grant (fx_grant), .busy (fx_busy), .bus_err (fx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   initial begin
      reset         = 1'b0;
      up_address    = '0;
      up_read       = '0;
      up_write      = '0;
      up_writedata  = '0;
      up_byteenable = '0;
      waitrequest   = 1'b0;
      readdata      = '0;
      step();
      step();
      chk("rst_uwr",   32'(rr_uwr),   32'h3);
      chk("rst_busy",  32'(rr_busy),  32'h0);
      chk("rst_read",  32'(rr_read),  32'h0);
      chk("rst_grant", 32'(rr_grant), 32'h0);
      chk("rst_rdata", rr_rdata,      32'h0);
      chk("rst_err",   32'(rr_err),   32'h0);
      reset = 1'b1;
      step();

      // Single read from requester 0, zero-wait slave
      readdata          = 32'h3C010001;
      up_address[31:0]  = 32'hBFC00000;
      up_read           = 2'b01;
      step();
      chk("t1_read",  32'(rr_read),  32'h1);
      chk("t1_addr",  rr_addr,       32'hBFC00000);
      chk("t1_grant", 32'(rr_grant), 32'h0);
      chk("t1_busy",  32'(rr_busy),  32'h1);
      chk("t1_uwr",   32'(rr_uwr),   32'h3);
      step();
      chk("t1_rdrop", 32'(rr_read),  32'h0);
      chk("t1_done",  32'(rr_uwr),   32'h2);
      chk("t1_rdata", rr_rdata,      32'h3C010001);
      step();
      chk("t1_uwr_idle", 32'(rr_uwr),  32'h3);
      chk("t1_idle",     32'(rr_busy), 32'h0);
      up_read = 2'b00;
      step();

      // Both requesters continuously requesting
      do_reset();
      up_address[63:32] = 32'h00002000;
      up_read           = 2'b11;
      for (int t = 0; t < 4; t++) begin
         step();
         chk($sformatf("t2_rr_grant%0d", t), 32'(rr_grant), 32'(t % 2));
         chk($sformatf("t2_fx_grant%0d", t), 32'(fx_grant), 32'h0);
         step();
         chk($sformatf("t2_rr_done%0d", t), 32'(rr_uwr), (t % 2 == 1) ? 32'h1 : 32'h2);
         chk($sformatf("t2_fx_done%0d", t), 32'(fx_uwr), 32'h2);
         step();
         chk($sformatf("t2_rr_idle%0d", t), 32'(rr_uwr), 32'h3);
      end
      up_read = 2'b10;
      step();
      chk("t2_fx_grant_r1", 32'(fx_grant), 32'h1);
      chk("t2_rr_grant_r1", 32'(rr_grant), 32'h1);
      chk("t2_fx_addr_r1",  fx_addr,       32'h00002000);
      step();
      chk("t2_fx_done_r1", 32'(fx_uwr), 32'h1);
      step();
      up_read = 2'b00;

      // Write from requester 1 with a 5-cycle waitrequest
      waitrequest           = 1'b1;
      up_address[63:32]     = 32'h00001000;
      up_writedata[63:32]   = 32'h12345678;
      up_byteenable[7:4]    = 4'b0011;
      up_write              = 2'b10;
      for (int c = 0; c < 6; c++) begin
         step();
         chk($sformatf("t3_addr%0d", c),  rr_addr,        32'h00001000);
         chk($sformatf("t3_wdata%0d", c), rr_wdata,       32'h12345678);
         chk($sformatf("t3_be%0d", c),    32'(rr_be),     32'h3);
         chk($sformatf("t3_write%0d", c), 32'(rr_write),  32'h1);
         chk($sformatf("t3_uwr%0d", c),   32'(rr_uwr),    32'h3);
         if (c == 5) waitrequest = 1'b0;
      end
      step();
      chk("t3_done",   32'(rr_uwr),   32'h1);
      chk("t3_wdrop",  32'(rr_write), 32'h0);
      chk("t3_grant",  32'(rr_grant), 32'h1);
      chk("t3_rdata",  rr_rdata,      32'h3C010001);
      step();
      up_write = 2'b00;

      // Slave hangs on a read: abort after 8 wait cycles
      waitrequest      = 1'b1;
      up_address[31:0] = 32'h80000040;
      up_read          = 2'b01;
      for (int c = 0; c < 8; c++) begin
         step();
         chk($sformatf("t4_read%0d", c), 32'(rr_read), 32'h1);
         chk($sformatf("t4_err%0d", c),  32'(rr_err),  32'h0);
      end
      step();
      chk("t4_rdrop", 32'(rr_read), 32'h0);
      chk("t4_err",   32'(rr_err),  32'h1);
      chk("t4_rdata", rr_rdata,     32'hDEADBEEF);
      chk("t4_done",  32'(rr_uwr),  32'h2);
      step();
      chk("t4_err_clr", 32'(rr_err),  32'h0);
      chk("t4_idle",    32'(rr_busy), 32'h0);
      chk("t4_uwr",     32'(rr_uwr),  32'h3);
      up_read     = 2'b00;
      waitrequest = 1'b0;
      step();

      // Reset asserted while in BUS
      waitrequest = 1'b1;
      up_read     = 2'b01;
      step();
      chk("t5_busy", 32'(rr_busy), 32'h1);
      step();
      #2;
      reset = 1'b0;
      #1;
      chk("t5_rst_read", 32'(rr_read), 32'h0);
      chk("t5_rst_busy", 32'(rr_busy), 32'h0);
      chk("t5_rst_uwr",  32'(rr_uwr),  32'h3);
      step();
      reset       = 1'b1;
      waitrequest = 1'b0;
      up_read     = 2'b11;
      step();
      chk("t5_grant", 32'(rr_grant), 32'h0);
      chk("t5_read",  32'(rr_read),  32'h1);
      step();
      step();
      up_read = 2'b00;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
